// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) has priority, and
// secondary writebacks (B) queue in a 4-entry FIFO that drains on A-idle cycles.
module wb_write_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ValidA,
  input  logic [4:0]  DstA,
  input  logic [31:0] DataA,
  input  logic        ReqB,
  input  logic [4:0]  DstB,
  input  logic [31:0] DataB,
  output logic        oReadyB,
  output logic        oStallA,
  output logic        oRegWrite,
  output logic [4:0]  oWriteReg,
  output logic [31:0] oWriteData,
  output logic        oSrcB,
  output logic [2:0]  oPendingB
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        r_valid;
  logic [3:0][4:0]   r_dst;
  logic [3:0][31:0]  r_data;
  logic [1:0]        r_head;
  logic [1:0]        r_tail;
  logic [2:0]        r_count;
  logic [3:0]        r_starve;

  logic              r_reg_write;
  logic [4:0]        r_write_reg;
  logic [31:0]       r_write_data;
  logic              r_src_b;

  logic              w_a_issue;
  logic              w_empty;
  logic              w_full;
  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_head_live;
  logic [2:0]        w_count_nxt;
  logic [3:0]        w_starve_nxt;

  // Issue decisions for this cycle; register 0 is never a real write target.
  always_comb begin
    w_a_issue   = ValidA && (DstA != 5'd0);
    w_empty     = (r_count == 3'd0);
    w_full      = (r_count == 3'd4);
    w_ready     = !w_full && !Reset;
    w_push      = ReqB && w_ready && (DstB != 5'd0);
    w_pop       = !w_empty && !w_a_issue;
    w_head_live = r_valid[r_head];
  end

  // Next occupancy and starvation count.
  always_comb begin
    w_count_nxt  = r_count;
    w_starve_nxt = r_starve;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 3'd1;
      2'b01:   w_count_nxt = r_count - 3'd1;
      default: w_count_nxt = r_count;
    endcase
    if (w_empty || w_pop) begin
      w_starve_nxt = 4'd0;
    end else if (w_a_issue && (r_starve != LP_LIMIT)) begin
      w_starve_nxt = r_starve + 4'd1;
    end else begin
      w_starve_nxt = r_starve;
    end
  end

  // FIFO storage; kills apply to older entries, then the same-cycle push lands live.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_valid <= 4'b0000;
      r_dst   <= '0;
      r_data  <= '0;
      r_head  <= 2'd0;
      r_tail  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_a_issue && (r_dst[i] == DstA)) begin
          r_valid[i] <= 1'b0;
        end
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_dst[r_tail]   <= DstB;
        r_data[r_tail]  <= DataB;
        r_tail          <= r_tail + 2'd1;
      end
      if (w_pop) begin
        r_head <= r_head + 2'd1;
      end
      r_count <= w_count_nxt;
    end
  end

  // Starvation counter that forces a one-cycle A stall.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_starve <= 4'd0;
    end else begin
      r_starve <= w_starve_nxt;
    end
  end

  // Registered write port; a killed head entry consumes the cycle without writing.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= 5'd0;
      r_write_data <= 32'd0;
      r_src_b      <= 1'b0;
    end else if (w_a_issue) begin
      r_reg_write  <= 1'b1;
      r_write_reg  <= DstA;
      r_write_data <= DataA;
      r_src_b      <= 1'b0;
    end else if (w_pop && w_head_live) begin
      r_reg_write  <= 1'b1;
      r_write_reg  <= r_dst[r_head];
      r_write_data <= r_data[r_head];
      r_src_b      <= 1'b1;
    end else begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= 5'd0;
      r_write_data <= 32'd0;
      r_src_b      <= 1'b0;
    end
  end

  assign oReadyB    = w_ready;
  assign oStallA    = (r_starve == LP_LIMIT);
  assign oRegWrite  = r_reg_write;
  assign oWriteReg  = r_write_reg;
  assign oWriteData = r_write_data;
  assign oSrcB      = r_src_b;
  assign oPendingB  = r_count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: expected writes are queued per source
// at drive time and matched when the DUT presents a register-file write.
module tb_wb_write_arbiter;

  logic        Clk;
  logic        Reset;
  logic        ValidA;
  logic [4:0]  DstA;
  logic [31:0] DataA;
  logic        ReqB;
  logic [4:0]  DstB;
  logic [31:0] DataB;
  logic        oReadyB;
  logic        oStallA;
  logic        oRegWrite;
  logic [4:0]  oWriteReg;
  logic [31:0] oWriteData;
  logic        oSrcB;
  logic [2:0]  oPendingB;

  int n_checks = 0;
  int n_errors = 0;

  logic [36:0] qa[$];
  logic [36:0] qb[$];
  logic [31:0] shadow [32];

  wb_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .ValidA(ValidA), .DstA(DstA), .DataA(DataA),
    .ReqB(ReqB), .DstB(DstB), .DataB(DataB),
    .oReadyB(oReadyB), .oStallA(oStallA),
    .oRegWrite(oRegWrite), .oWriteReg(oWriteReg), .oWriteData(oWriteData),
    .oSrcB(oSrcB), .oPendingB(oPendingB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Write monitor: every write must match the head of its source queue.
  always @(negedge Clk) begin
    logic [36:0] exp_w;
    if (oRegWrite) begin
      if (oSrcB) begin
        if (qb.size() == 0) begin
          check_val("unexpected_b_write", {oRegWrite, oWriteReg, oWriteData}, 64'd0);
        end else begin
          exp_w = qb.pop_front();
          check_val("b_write", {oWriteReg, oWriteData}, exp_w);
        end
      end else begin
        if (qa.size() == 0) begin
          check_val("unexpected_a_write", {oRegWrite, oWriteReg, oWriteData}, 64'd0);
        end else begin
          exp_w = qa.pop_front();
          check_val("a_write", {oWriteReg, oWriteData}, exp_w);
        end
      end
      shadow[oWriteReg] = oWriteData;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
    Reset = 1'b1; ValidA = 1'b0; DstA = 5'd0; DataA = 32'd0;
    ReqB = 1'b0; DstB = 5'd0; DataB = 32'd0;
    step();
    step();
    check_val("rst_ready", oReadyB, 0);
    check_val("rst_regwrite", oRegWrite, 0);
    check_val("rst_pending", oPendingB, 0);
    check_val("rst_stall", oStallA, 0);
    check_val("rst_wreg", oWriteReg, 0);
    check_val("rst_wdata", oWriteData, 0);
    Reset = 1'b0;
    step();
    check_val("ready_after_rst", oReadyB, 1);

    // A only
    ValidA = 1'b1; DstA = 5'd5; DataA = 32'h1234;
    qa.push_back({5'd5, 32'h1234});
    step();
    ValidA = 1'b0;
    check_val("a_regwrite", oRegWrite, 1);
    check_val("a_wreg", oWriteReg, 5);
    check_val("a_wdata", oWriteData, 32'h1234);
    check_val("a_srcb", oSrcB, 0);

    // B drain through an empty FIFO
    ReqB = 1'b1; DstB = 5'd7; DataB = 32'hAA;
    qb.push_back({5'd7, 32'hAA});
    step();
    ReqB = 1'b0;
    check_val("b_pending_t1", oPendingB, 1);
    check_val("b_nowrite_t1", oRegWrite, 0);
    step();
    check_val("b_pending_t2", oPendingB, 0);
    check_val("b_regwrite_t2", oRegWrite, 1);
    check_val("b_wreg_t2", oWriteReg, 7);
    check_val("b_srcb_t2", oSrcB, 1);

    // Fill FIFO under continuous A traffic, then starve
    ValidA = 1'b1; DstA = 5'd1;
    for (int k = 0; k < 4; k++) begin
      DataA = 32'h100 + 32'(k);
      ReqB = 1'b1; DstB = 5'(10 + k); DataB = 32'hB0 + 32'(k);
      qa.push_back({5'd1, 32'h100 + 32'(k)});
      qb.push_back({5'(10 + k), 32'hB0 + 32'(k)});
      step();
      check_val("no_stall_early", oStallA, 0);
    end
    check_val("full_pending", oPendingB, 4);
    check_val("full_ready", oReadyB, 0);
    DataA = 32'h104; DstB = 5'd14; DataB = 32'hB4;
    qa.push_back({5'd1, 32'h104});
    step();
    check_val("full_refused", oPendingB, 4);
    check_val("stall_rise", oStallA, 1);
    ValidA = 1'b0;
    step();
    check_val("stall_drop", oStallA, 0);
    check_val("starve_pop_write", oRegWrite, 1);
    check_val("starve_pop_srcb", oSrcB, 1);
    check_val("starve_pop_reg", oWriteReg, 10);
    check_val("after_pop_pending", oPendingB, 3);
    check_val("after_pop_ready", oReadyB, 1);
    qb.push_back({5'd14, 32'hB4});
    step();
    ReqB = 1'b0;
    check_val("push_pop_pending", oPendingB, 3);
    repeat (3) step();
    check_val("drained_pending", oPendingB, 0);
    step();

    // Kill rule
    ReqB = 1'b1; DstB = 5'd9; DataB = 32'h11;
    step();
    check_val("kill_pre_pending", oPendingB, 1);
    ValidA = 1'b1; DstA = 5'd9; DataA = 32'h22;
    DstB = 5'd9; DataB = 32'h33;
    qa.push_back({5'd9, 32'h22});
    qb.push_back({5'd9, 32'h33});
    step();
    ValidA = 1'b0; ReqB = 1'b0;
    check_val("kill_a_data", oWriteData, 32'h22);
    check_val("kill_pending2", oPendingB, 2);
    step();
    check_val("killed_pop_nowrite", oRegWrite, 0);
    check_val("killed_pop_pending", oPendingB, 1);
    step();
    check_val("live_push_write", oRegWrite, 1);
    check_val("live_push_data", oWriteData, 32'h33);
    check_val("kill_end_pending", oPendingB, 0);

    // Register 0 from both sources
    ValidA = 1'b1; DstA = 5'd0; DataA = 32'hDEAD;
    ReqB = 1'b1; DstB = 5'd0; DataB = 32'hBEEF;
    check_val("reg0_ready", oReadyB, 1);
    step();
    ValidA = 1'b0; ReqB = 1'b0;
    check_val("reg0_nowrite", oRegWrite, 0);
    check_val("reg0_pending", oPendingB, 0);
    step();
    check_val("reg0_nowrite2", oRegWrite, 0);

    // Reset mid-operation with 3 entries pending
    ValidA = 1'b1; DstA = 5'd2;
    for (int k = 0; k < 3; k++) begin
      DataA = 32'h200 + 32'(k);
      ReqB = 1'b1; DstB = 5'(20 + k); DataB = 32'hC0 + 32'(k);
      qa.push_back({5'd2, 32'h200 + 32'(k)});
      step();
    end
    check_val("pre_rst_pending", oPendingB, 3);
    Reset = 1'b1; ValidA = 1'b0; ReqB = 1'b0;
    step();
    check_val("mid_rst_regwrite", oRegWrite, 0);
    check_val("mid_rst_pending", oPendingB, 0);
    check_val("mid_rst_ready", oReadyB, 0);
    check_val("mid_rst_stall", oStallA, 0);
    Reset = 1'b0;
    repeat (6) step();
    check_val("post_rst_pending", oPendingB, 0);

    check_val("qa_empty", 64'(qa.size()), 0);
    check_val("qb_empty", 64'(qb.size()), 0);
    check_val("final_r5", shadow[5], 32'h1234);
    check_val("final_r7", shadow[7], 32'hAA);
    check_val("final_r9", shadow[9], 32'h33);
    check_val("final_r14", shadow[14], 32'hB4);
    check_val("final_r20", shadow[20], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
